// File: rtl/tc_pwl_calc.sv
// Piecewise-linear thermocouple linearizer: ADC code -> signed degC through a
// writable slope/intercept table, plus cold-junction offset and output clamp.
module tc_pwl_calc #(
    parameter int CODE_W    = 10,
    parameter int SEC_BITS  = 3,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 4,
    parameter int TEMP_W    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [CODE_W-1:0]        i_code,
    input  logic [TEMP_W-1:0]        i_cj_temp,
    input  logic                     i_wr_en,
    input  logic                     i_wr_sel,
    input  logic [SEC_BITS-1:0]      i_wr_addr,
    input  logic [COEF_W-1:0]        i_wr_data,
    output logic                     o_busy,
    output logic [TEMP_W-1:0]        o_temp,
    output logic                     o_done,
    output logic                     o_sat
);
    localparam int NSEC   = 2 ** SEC_BITS;
    localparam int VAL_W  = CODE_W - SEC_BITS;
    localparam int PROD_W = COEF_W + VAL_W + 1;
    localparam int SH_W   = COEF_W + FRAC_BITS;
    localparam int ACC_W  = ((PROD_W > SH_W) ? PROD_W : SH_W) + 2;
    localparam int T_W    = (((ACC_W - FRAC_BITS) > TEMP_W) ? (ACC_W - FRAC_BITS) : TEMP_W) + 1;

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [T_W-1:0]   T_MAX = T_W'((2 ** (TEMP_W - 1)) - 1);
    localparam logic signed [T_W-1:0]   T_MIN = ~T_MAX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_SUM  = 2'd3
    } state_t;

    state_t state;

    logic signed [COEF_W-1:0] slope_tbl [NSEC];
    logic signed [COEF_W-1:0] icpt_tbl  [NSEC];

    logic [SEC_BITS-1:0]      sec_r;
    logic [VAL_W-1:0]         val_r;
    logic signed [TEMP_W-1:0] cj_r;
    logic signed [COEF_W-1:0] slope_r;
    logic signed [COEF_W-1:0] icpt_r;
    logic signed [PROD_W-1:0] prod_r;

    logic signed [ACC_W-1:0]  acc;
    logic signed [T_W-1:0]    t_full;
    logic [TEMP_W-1:0]        t_clamped;
    logic                     t_sat;

    // Reset values make the table an identity map (temp == code).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < NSEC; s++) begin
                slope_tbl[s] <= COEF_W'(1) << FRAC_BITS;
                icpt_tbl[s]  <= COEF_W'(s) << VAL_W;
            end
        end else if (i_wr_en) begin
            if (i_wr_sel) icpt_tbl[i_wr_addr]  <= i_wr_data;
            else          slope_tbl[i_wr_addr] <= i_wr_data;
        end
    end

    // Round half up in Q.FRAC_BITS, then add cold junction and clamp.
    always_comb begin
        acc       = (ACC_W'(icpt_r) <<< FRAC_BITS) + ACC_W'(prod_r) + HALF;
        t_full    = T_W'(acc >>> FRAC_BITS) + T_W'(cj_r);
        t_clamped = TEMP_W'(t_full);
        t_sat     = 1'b0;
        if (t_full > T_MAX) begin
            t_clamped = TEMP_W'(T_MAX);
            t_sat     = 1'b1;
        end else if (t_full < T_MIN) begin
            t_clamped = TEMP_W'(T_MIN);
            t_sat     = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            o_temp  <= '0;
            o_sat   <= 1'b0;
            o_done  <= 1'b0;
            sec_r   <= '0;
            val_r   <= '0;
            cj_r    <= '0;
            slope_r <= '0;
            icpt_r  <= '0;
            prod_r  <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        sec_r <= i_code[CODE_W-1 -: SEC_BITS];
                        val_r <= i_code[VAL_W-1:0];
                        cj_r  <= i_cj_temp;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    slope_r <= slope_tbl[sec_r];
                    icpt_r  <= icpt_tbl[sec_r];
                    state   <= ST_MUL;
                end
                ST_MUL: begin
                    prod_r <= PROD_W'(slope_r) * PROD_W'($signed({1'b0, val_r}));
                    state  <= ST_SUM;
                end
                ST_SUM: begin
                    o_temp <= t_clamped;
                    o_sat  <= t_sat;
                    o_done <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_tc_pwl_calc.sv
// Bench for tc_pwl_calc: directed scenarios plus random conversions against a
// real-arithmetic reference of the linearizer.
module tb_tc_pwl_calc;
    localparam int CODE_W = 10, SEC_BITS = 3, COEF_W = 16, FRAC_BITS = 4, TEMP_W = 16;
    localparam int VAL_W = CODE_W - SEC_BITS;
    localparam int NSEC  = 2 ** SEC_BITS;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_start = 1'b0;
    logic [CODE_W-1:0]   i_code = '0;
    logic [TEMP_W-1:0]   i_cj_temp = '0;
    logic                i_wr_en = 1'b0;
    logic                i_wr_sel = 1'b0;
    logic [SEC_BITS-1:0] i_wr_addr = '0;
    logic [COEF_W-1:0]   i_wr_data = '0;
    logic                o_busy;
    logic [TEMP_W-1:0]   o_temp;
    logic                o_done;
    logic                o_sat;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    int m_slope [NSEC];
    int m_icpt  [NSEC];

    logic [TEMP_W:0] exp_q[$];

    tc_pwl_calc #(
        .CODE_W(CODE_W), .SEC_BITS(SEC_BITS), .COEF_W(COEF_W),
        .FRAC_BITS(FRAC_BITS), .TEMP_W(TEMP_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_code(i_code),
        .i_cj_temp(i_cj_temp), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_busy(o_busy),
        .o_temp(o_temp), .o_done(o_done), .o_sat(o_sat)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NSEC; s++) begin
            m_slope[s] = 16;
            m_icpt[s]  = s * (2 ** VAL_W);
        end
    endtask

    // Reference: temp = floor(intercept + slope*val + 0.5) + cj, clamped.
    function automatic logic [TEMP_W:0] model(input int code, input int cj);
        int     sec;
        int     val;
        real    x;
        longint t;
        logic   sat;
        sec = code / (2 ** VAL_W);
        val = code % (2 ** VAL_W);
        x   = real'(m_icpt[sec]) + real'(m_slope[sec]) * real'(val) / 16.0 + 0.5;
        t   = longint'($floor(x)) + longint'(cj);
        sat = 1'b0;
        if (t > 32767)       begin t = 32767;  sat = 1'b1; end
        else if (t < -32768) begin t = -32768; sat = 1'b1; end
        return {sat, TEMP_W'(t)};
    endfunction

    // Scoreboard: every o_done pulse consumes one expected result.
    always @(negedge clk) begin
        if (o_done) begin
            logic [TEMP_W:0] e;
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("temp", 32'(o_temp), 32'(e[TEMP_W-1:0]));
                check("sat", 32'(o_sat), 32'(e[TEMP_W]));
            end
        end
    end

    // Driver tasks
    task automatic wr_coef(input logic sel, input int addr, input int data);
        @(negedge clk);
        i_wr_en   = 1'b1;
        i_wr_sel  = sel;
        i_wr_addr = SEC_BITS'(addr);
        i_wr_data = COEF_W'(data);
        if (sel) m_icpt[addr] = data;
        else     m_slope[addr] = data;
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    task automatic start_conv(input int code, input int cj);
        @(negedge clk);
        i_start   = 1'b1;
        i_code    = CODE_W'(code);
        i_cj_temp = TEMP_W'(cj);
        exp_q.push_back(model(code, cj));
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);
    endtask

    // Waits (bounded) for o_done; cycle count is from the accepting edge.
    task automatic wait_done(input int elapsed);
        int  i;
        logic got;
        i   = elapsed;
        got = 1'b0;
        while (i < 12 && !got) begin
            @(negedge clk);
            i++;
            got = o_done;
            if (!got) check("busy_while_conv", 32'(o_busy), 32'd1);
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(i), 32'd4);
        check("busy_at_done", 32'(o_busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(o_done), 32'd0);
    endtask

    task automatic conv(input int code, input int cj);
        start_conv(code, cj);
        wait_done(1);
    endtask

    initial begin
        int d0;
        int hits;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_temp", 32'(o_temp), 32'd0);
        check("rst_sat", 32'(o_sat), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);

        // Identity map and basic latency
        conv(300, 0);
        conv(1023, 0);
        conv(0, 0);

        // Custom section
        wr_coef(1'b0, 2, 24);
        wr_coef(1'b1, 2, 250);
        conv(266, 25);

        // Rounding, half-up in both signs
        wr_coef(1'b0, 0, 1);
        wr_coef(1'b1, 0, 0);
        conv(8, 0);
        conv(7, 0);
        wr_coef(1'b0, 0, -1);
        conv(8, 0);

        // Saturation high / low, then a clear
        wr_coef(1'b1, 7, 32000);
        wr_coef(1'b0, 7, 32767);
        conv(1023, 0);
        wr_coef(1'b1, 0, -32768);
        wr_coef(1'b0, 0, 0);
        conv(0, -100);
        conv(0, 100);

        // Start held high: one conversion every 4 cycles
        @(negedge clk);
        i_start = 1'b1;
        i_code  = CODE_W'(600);
        i_cj_temp = TEMP_W'(-7);
        for (int k = 0; k < 4; k++) exp_q.push_back(model(600, -7));
        hits = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 13) i_start = 1'b0;
            if (o_done) begin
                hits++;
                check("held_start_phase", 32'(i % 4), 32'd0);
            end
        end
        check("held_start_count", 32'(hits), 32'd4);
        repeat (3) @(negedge clk);

        // Start pulse while busy is ignored
        d0 = n_done;
        start_conv(777, 3);
        i_start = 1'b1;
        i_code  = CODE_W'(5);
        @(negedge clk);
        i_start = 1'b0;
        wait_done(2);
        repeat (6) @(negedge clk);
        check("busy_start_ignored", 32'(n_done - d0), 32'd1);

        // Write hazard: write in LOAD cycle uses old slope
        @(negedge clk);
        i_start = 1'b1;
        i_code  = CODE_W'(130);
        i_cj_temp = '0;
        exp_q.push_back(model(130, 0));
        @(negedge clk);
        i_start   = 1'b0;
        i_wr_en   = 1'b1;
        i_wr_sel  = 1'b0;
        i_wr_addr = SEC_BITS'(1);
        i_wr_data = COEF_W'(48);
        m_slope[1] = 48;
        @(negedge clk);
        i_wr_en = 1'b0;
        wait_done(2);
        check("hazard_model_next", 32'(model(130, 0)), 32'd134);
        conv(130, 0);

        // Reset in MUL aborts conversion and restores the table
        d0 = n_done;
        @(negedge clk);
        i_start = 1'b1;
        i_code  = CODE_W'(900);
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        i_start = 1'b0;
        exp_q.delete();
        model_reset();
        check("abort_busy", 32'(o_busy), 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        check("abort_temp", 32'(o_temp), 32'd0);
        check("abort_sat", 32'(o_sat), 32'd0);
        conv(5, 0);
        conv(266, 0);
        conv(1023, 0);

        // Random table writes and conversions
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0)
                wr_coef(1'b0, int'($urandom_range(0, NSEC - 1)), int'($urandom_range(0, 65535)) - 32768);
            if ($urandom_range(0, 2) == 0)
                wr_coef(1'b1, int'($urandom_range(0, NSEC - 1)), int'($urandom_range(0, 65535)) - 32768);
            conv(int'($urandom_range(0, 1023)), int'($urandom_range(0, 400)) - 200);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
